pong_vga_renderer: RTL and testbench

PONG_VGA_RENDERER -- requirements
Module: pong_vga_renderer

---
 rtl/pong_pkg.sv | 60 ++++++
 rtl/vga_timing.sv | 59 +++++
 rtl/pong_vga_renderer.sv | 147 ++++++++++++++
 tb/tb_pong_vga_renderer.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// pong_pkg: shared timing defaults, playfield geometry and
// colour constants for the pong VGA renderer.
package pong_pkg;

  localparam int H_ACTIVE_D     = 640;
  localparam int H_TOTAL_D      = 800;
  localparam int H_SYNC_START_D = 656;
  localparam int H_SYNC_END_D   = 752;
  localparam int V_ACTIVE_D     = 480;
  localparam int V_TOTAL_D      = 525;
  localparam int V_SYNC_START_D = 490;
  localparam int V_SYNC_END_D   = 492;

  localparam int WALL      = 10;
  localparam int BALL_SZ   = 10;
  localparam int PAD_H     = 50;
  localparam int P1_X_LO   = 39;
  localparam int P1_X_HI   = 49;
  // paddle2 sits at a fixed distance from the right edge
  localparam int P2_OFS_LO = 50;
  localparam int P2_OFS_HI = 40;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  localparam rgb_t C_BALL = '{r: 4'hF, g: 4'hF, b: 4'h0};
  localparam rgb_t C_PAD1 = '{r: 4'h0, g: 4'hF, b: 4'hF};
  localparam rgb_t C_PAD2 = '{r: 4'hF, g: 4'h0, b: 4'hF};
  localparam rgb_t C_WALL = '{r: 4'hF, g: 4'hF, b: 4'hF};
  localparam rgb_t C_BG   = '{r: 4'h0, g: 4'h0, b: 4'h0};

  typedef struct packed {
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic [9:0] paddle1_y;
    logic [9:0] paddle2_y;
    logic       stop;
  } shadow_t;

  localparam shadow_t SH_RST = '{
    ball_x:    10'd319,
    ball_y:    10'd239,
    paddle1_y: 10'd214,
    paddle2_y: 10'd214,
    stop:      1'b1
  };

  // 11-bit span test: lo+len cannot wrap for 10-bit lo
  function automatic logic in_span(
    input logic [10:0] p,
    input logic [10:0] lo,
    input logic [10:0] len
  );
    return (p >= lo) && (p < (lo + len));
  endfunction

endpackage

// File: rtl/vga_timing.sv
// vga_timing: pixel enable, h/v counters, raw sync
// and active-area flags for the pong renderer.
module vga_timing
  import pong_pkg::*;
#(
  parameter int H_ACTIVE     = H_ACTIVE_D,
  parameter int H_TOTAL      = H_TOTAL_D,
  parameter int H_SYNC_START = H_SYNC_START_D,
  parameter int H_SYNC_END   = H_SYNC_END_D,
  parameter int V_ACTIVE     = V_ACTIVE_D,
  parameter int V_TOTAL      = V_TOTAL_D,
  parameter int V_SYNC_START = V_SYNC_START_D,
  parameter int V_SYNC_END   = V_SYNC_END_D
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_en,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       active,
  output logic       hsync_raw,
  output logic       vsync_raw
);

  logic phase;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase <= 1'b0;
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      phase <= ~phase;
      if (phase) begin
        if (h_cnt == 10'(H_TOTAL - 1)) begin
          h_cnt <= '0;
          if (v_cnt == 10'(V_TOTAL - 1))
            v_cnt <= '0;
          else
            v_cnt <= v_cnt + 10'd1;
        end else begin
          h_cnt <= h_cnt + 10'd1;
        end
      end
    end
  end

  assign pix_en = phase;

  assign active = (h_cnt < 10'(H_ACTIVE)) &&
                  (v_cnt < 10'(V_ACTIVE));

  assign hsync_raw = !((h_cnt >= 10'(H_SYNC_START)) &&
                       (h_cnt <  10'(H_SYNC_END)));

  assign vsync_raw = !((v_cnt >= 10'(V_SYNC_START)) &&
                       (v_cnt <  10'(V_SYNC_END)));

endmodule

// File: rtl/pong_vga_renderer.sv
// pong_vga_renderer: frame-latched game state, object
// compare and registered VGA sync/colour outputs.
module pong_vga_renderer
  import pong_pkg::*;
#(
  parameter int H_ACTIVE     = H_ACTIVE_D,
  parameter int V_ACTIVE     = V_ACTIVE_D,
  parameter int H_TOTAL      = H_TOTAL_D,
  parameter int H_SYNC_START = H_SYNC_START_D,
  parameter int H_SYNC_END   = H_SYNC_END_D,
  parameter int V_TOTAL      = V_TOTAL_D,
  parameter int V_SYNC_START = V_SYNC_START_D,
  parameter int V_SYNC_END   = V_SYNC_END_D
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] ball_x,
  input  logic [9:0] ball_y,
  input  logic [9:0] paddle1_y,
  input  logic [9:0] paddle2_y,
  input  logic       stop,
  output logic       hsync,
  output logic       vsync,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       frame_tick
);

  logic       pix_en;
  logic [9:0] h_cnt;
  logic [9:0] v_cnt;
  logic       active;
  logic       hsync_raw;
  logic       vsync_raw;

  vga_timing #(
    .H_ACTIVE     (H_ACTIVE),
    .H_TOTAL      (H_TOTAL),
    .H_SYNC_START (H_SYNC_START),
    .H_SYNC_END   (H_SYNC_END),
    .V_ACTIVE     (V_ACTIVE),
    .V_TOTAL      (V_TOTAL),
    .V_SYNC_START (V_SYNC_START),
    .V_SYNC_END   (V_SYNC_END)
  ) u_timing (
    .clk       (clk),
    .rst       (rst),
    .pix_en    (pix_en),
    .h_cnt     (h_cnt),
    .v_cnt     (v_cnt),
    .active    (active),
    .hsync_raw (hsync_raw),
    .vsync_raw (vsync_raw)
  );

  shadow_t sh;
  logic    latch;

  // first blanking pixel of a frame: safe point to sample game state
  assign latch = pix_en && (h_cnt == 10'd0) &&
                 (v_cnt == 10'(V_ACTIVE));
  assign frame_tick = latch;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh <= SH_RST;
    end else if (latch) begin
      sh <= '{
        ball_x:    ball_x,
        ball_y:    ball_y,
        paddle1_y: paddle1_y,
        paddle2_y: paddle2_y,
        stop:      stop
      };
    end
  end

  logic [10:0] hx;
  logic [10:0] vy;
  logic        ball_on;
  logic        p1_on;
  logic        p2_on;
  logic        wall_on;

  assign hx = {1'b0, h_cnt};
  assign vy = {1'b0, v_cnt};

  assign ball_on = !sh.stop &&
    in_span(hx, {1'b0, sh.ball_x}, 11'(BALL_SZ)) &&
    in_span(vy, {1'b0, sh.ball_y}, 11'(BALL_SZ));

  assign p1_on = (hx >= 11'(P1_X_LO)) &&
                 (hx <= 11'(P1_X_HI)) &&
    in_span(vy, {1'b0, sh.paddle1_y}, 11'(PAD_H));

  assign p2_on = (hx >= 11'(H_ACTIVE - P2_OFS_LO)) &&
                 (hx <= 11'(H_ACTIVE - P2_OFS_HI)) &&
    in_span(vy, {1'b0, sh.paddle2_y}, 11'(PAD_H));

  assign wall_on = (hx <  11'(WALL)) ||
                   (hx >= 11'(H_ACTIVE - WALL)) ||
                   (vy <  11'(WALL)) ||
                   (vy >= 11'(V_ACTIVE - WALL));

  // one-hot selects encode the colour priority
  logic sel_ball;
  logic sel_p1;
  logic sel_p2;
  logic sel_wall;

  assign sel_ball = active && ball_on;
  assign sel_p1   = active && !ball_on && p1_on;
  assign sel_p2   = active && !ball_on && !p1_on && p2_on;
  assign sel_wall = active && !ball_on && !p1_on &&
                    !p2_on && wall_on;

  rgb_t pix;

  always_comb begin
    pix = C_BG;
    unique case (1'b1)
      sel_ball: pix = C_BALL;
      sel_p1:   pix = C_PAD1;
      sel_p2:   pix = C_PAD2;
      sel_wall: pix = C_WALL;
      default:  pix = C_BG;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hsync <= 1'b1;
      vsync <= 1'b1;
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end else if (pix_en) begin
      hsync <= hsync_raw;
      vsync <= vsync_raw;
      red   <= pix.r;
      green <= pix.g;
      blue  <= pix.b;
    end
  end

endmodule

// File: tb/tb_pong_vga_renderer.sv
// tb_pong_vga_renderer: scoreboard bench on a shrunken
// raster, frame-level reference model of the picture.
module tb_pong_vga_renderer;

  localparam int HA   = 96;
  localparam int HSS  = 98;
  localparam int HSE  = 102;
  localparam int HT   = 104;
  localparam int VA   = 64;
  localparam int VSS  = 65;
  localparam int VSE  = 67;
  localparam int VT   = 68;
  localparam int LINE = HT * 2;
  localparam int FR   = LINE * VT;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [9:0] ball_x;
  logic [9:0] ball_y;
  logic [9:0] paddle1_y;
  logic [9:0] paddle2_y;
  logic       stop;
  logic       hsync;
  logic       vsync;
  logic [3:0] red;
  logic [3:0] green;
  logic [3:0] blue;
  logic       frame_tick;

  always #5 clk = ~clk;

  pong_vga_renderer #(
    .H_ACTIVE     (HA),
    .V_ACTIVE     (VA),
    .H_TOTAL      (HT),
    .H_SYNC_START (HSS),
    .H_SYNC_END   (HSE),
    .V_TOTAL      (VT),
    .V_SYNC_START (VSS),
    .V_SYNC_END   (VSE)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ball_x     (ball_x),
    .ball_y     (ball_y),
    .paddle1_y  (paddle1_y),
    .paddle2_y  (paddle2_y),
    .stop       (stop),
    .hsync      (hsync),
    .vsync      (vsync),
    .red        (red),
    .green      (green),
    .blue       (blue),
    .frame_tick (frame_tick)
  );

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
    logic        ft;
  } exp_t;

  localparam exp_t RST_E = '{hs: 1'b1, vs: 1'b1,
                             rgb: 12'h000, ft: 1'b0};

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // model state: shadow copy of the game state per frame
  int n;
  int s_bx, s_by, s_p1, s_p2;
  bit s_stop;
  exp_t last;

  function automatic exp_t px(input int k);
    exp_t e;
    int h, v;
    bit act, b, p1, p2, w;
    h = k % HT;
    v = (k / HT) % VT;
    e.hs = !(h >= HSS && h < HSE);
    e.vs = !(v >= VSS && v < VSE);
    e.ft = 1'b0;
    act = (h < HA) && (v < VA);
    b  = !s_stop && h >= s_bx && h <= s_bx + 9 &&
         v >= s_by && v <= s_by + 9;
    p1 = h >= 39 && h <= 49 && v >= s_p1 && v <= s_p1 + 49;
    p2 = h >= HA - 50 && h <= HA - 40 &&
         v >= s_p2 && v <= s_p2 + 49;
    w  = h < 10 || h >= HA - 10 || v < 10 || v >= VA - 10;
    if (!act)    e.rgb = 12'h000;
    else if (b)  e.rgb = 12'hFF0;
    else if (p1) e.rgb = 12'h0FF;
    else if (p2) e.rgb = 12'hF0F;
    else if (w)  e.rgb = 12'hFFF;
    else         e.rgb = 12'h000;
    return e;
  endfunction

  // n = clock edges since reset release; a new pixel
  // is shown after every even edge, lagging one pixel
  always @(posedge clk) begin
    exp_t e;
    int k, kk;
    if (!rst) begin
      n = 0;
      s_bx = 319; s_by = 239;
      s_p1 = 214; s_p2 = 214;
      s_stop = 1'b1;
      last = RST_E;
      e = RST_E;
    end else begin
      n++;
      if (n % 2 == 0) begin
        k = n / 2 - 1;
        last = px(k);
        if (k % HT == 0 && (k / HT) % VT == VA) begin
          s_bx = int'(ball_x); s_by = int'(ball_y);
          s_p1 = int'(paddle1_y); s_p2 = int'(paddle2_y);
          s_stop = stop;
        end
      end
      e = last;
      kk = n / 2;
      e.ft = (n % 2 == 1) && (kk % HT == 0) &&
             ((kk / HT) % VT == VA);
    end
    q.push_back(e);
  end

  int cyc = 0;
  int last_ft = -1;
  int last_hf = -1;
  int hrun = 0;
  bit prev_hs = 1'b1;

  always @(negedge clk) begin
    exp_t e, g;
    cyc++;
    g = {hsync, vsync, red, green, blue, frame_tick};
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL queue_empty t=%0t", $time);
    end else begin
      e = q.pop_front();
      if (!rst) e = RST_E;
      if (g !== e) begin
        errors++;
        $display("FAIL pixel t=%0t got hs=%b vs=%b rgb=%h ft=%b exp hs=%b vs=%b rgb=%h ft=%b",
                 $time, g.hs, g.vs, g.rgb, g.ft,
                 e.hs, e.vs, e.rgb, e.ft);
      end
    end
    if (!rst) begin
      last_ft = -1; last_hf = -1;
      hrun = 0; prev_hs = 1'b1;
    end else begin
      if (frame_tick === 1'b1) begin
        if (last_ft >= 0) begin
          checks++;
          if (cyc - last_ft != FR) begin
            errors++;
            $display("FAIL frame_period got %0d exp %0d",
                     cyc - last_ft, FR);
          end
        end
        last_ft = cyc;
      end
      if (hsync === 1'b0) hrun++;
      if (prev_hs && hsync === 1'b0) begin
        if (last_hf >= 0) begin
          checks++;
          if (cyc - last_hf != LINE) begin
            errors++;
            $display("FAIL line_period got %0d exp %0d",
                     cyc - last_hf, LINE);
          end
        end
        last_hf = cyc;
      end
      if (!prev_hs && hsync === 1'b1) begin
        checks++;
        if (hrun != (HSE - HSS) * 2) begin
          errors++;
          $display("FAIL hsync_width got %0d exp %0d",
                   hrun, (HSE - HSS) * 2);
        end
        hrun = 0;
      end
      prev_hs = (hsync !== 1'b0);
    end
  end

  int el = 0;

  task automatic go_to(input int c);
    while (el < c) begin
      @(posedge clk);
      #1;
      el++;
    end
  endtask

  task automatic rnd_inputs();
    ball_x    = 10'($urandom_range(0, 110));
    ball_y    = 10'($urandom_range(0, 75));
    paddle1_y = 10'($urandom_range(0, 70));
    paddle2_y = 10'($urandom_range(0, 70));
    stop      = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 7) == 0)
      ball_x = 10'($urandom_range(900, 1023));
  endtask

  task automatic churn(input int c);
    while (el < c) begin
      go_to((el + 73 < c) ? el + 73 : c);
      rnd_inputs();
    end
  endtask

  task automatic set_state(input int bx, input int by,
                           input int p1, input int p2,
                           input bit st);
    ball_x = 10'(bx); ball_y = 10'(by);
    paddle1_y = 10'(p1); paddle2_y = 10'(p2);
    stop = st;
  endtask

  initial begin
    rnd_inputs();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    el = 0;
    // frame 0 draws reset state; churn must not leak in
    churn(40 * LINE);
    set_state(60, 30, 14, 44, 1'b0);
    // frame 1: change mid-frame, visible only in frame 2
    go_to(FR + 20 * LINE);
    ball_x = 10'd20;
    // frame 2: schedule off-screen ball for frame 3
    go_to(2 * FR + 5 * LINE);
    churn(2 * FR + 20 * LINE);
    set_state(1020, 30, 5, 44, 1'b0);
    // frame 3: reset partway through
    go_to(3 * FR + 30 * LINE);
    rst = 1'b0;
    go_to(el + 7);
    rst = 1'b1;
    el = 0;
    churn(50 * LINE);
    set_state(30, 40, 20, 8, 1'b0);
    go_to(FR + 12 * LINE);
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
